video_timing_gen: RTL and testbench

//  Parametrised raster timing generator for arcade cores: H/V counters, blanking,

---
 rtl/video_timing_gen.sv | 88 ++++++++
 tb/tb_video_timing_gen.sv | 134 +++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster H/V counters, blanking, active-low syncs and blank-gated RGB
// advancing on a pixel clock enable inside clk_sys, with column mask and sync centring.
module video_timing_gen #(
  parameter int H_TOTAL      = 318,
  parameter int H_ACTIVE     = 256,
  parameter int H_SYNC_START = 283,
  parameter int H_SYNC_END   = 303,
  parameter int H_MASK       = 5,
  parameter int V_TOTAL      = 256,
  parameter int V_ACTIVE     = 240,
  parameter int V_SYNC_START = 251,
  parameter int V_SYNC_END   = 254,
  parameter int RGB_W        = 24
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic                         ce_pix,
  input  logic                         mask_en,
  input  logic [3:0]                   h_adj,
  input  logic [RGB_W-1:0]             rgb_in,
  output logic [RGB_W-1:0]             rgb_out,
  output logic [$clog2(H_TOTAL)-1:0]   hcnt,
  output logic [$clog2(V_TOTAL)-1:0]   vcnt,
  output logic                         hb,
  output logic                         vb,
  output logic                         hs,
  output logic                         vs,
  output logic                         line_start,
  output logic                         frame_start
);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_MSK = HW'(H_MASK);
  localparam logic signed [HW:0] HS_ON = (HW+1)'(H_SYNC_START);
  localparam logic signed [HW:0] HS_OFF = (HW+1)'(H_SYNC_END);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_ON = VW'(V_SYNC_START);
  localparam logic [VW-1:0] VS_OFF = VW'(V_SYNC_END);
  logic signed [3:0] adj_q;
  logic signed [HW:0] adj_x, h_s;
  logic [HW-1:0] hcnt_n;
  logic [VW-1:0] vcnt_n;
  logic h_wrap, hb_n, vb_n, hs_n, vs_n;
  always_comb begin
    h_wrap = hcnt == H_LAST;
    hcnt_n = h_wrap ? '0 : hcnt + 1'b1;
    vcnt_n = !h_wrap ? vcnt : (vcnt == V_LAST ? '0 : vcnt + 1'b1);
    adj_x = {{(HW-3){adj_q[3]}}, adj_q};
    h_s = $signed({1'b0, hcnt_n});
    hb_n = (hcnt_n >= H_ACT) || (mask_en && hcnt_n < H_MSK);
    vb_n = vcnt_n >= V_ACT;
    hs_n = !(h_s >= HS_ON + adj_x && h_s < HS_OFF + adj_x);
    vs_n = !(vcnt_n >= VS_ON && vcnt_n < VS_OFF);
  end
  // Flags are decoded from the next count so they always line up with the shown hcnt/vcnt
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
      hb <= 1'b1;
      vb <= 1'b1;
      hs <= 1'b1;
      vs <= 1'b1;
      rgb_out <= '0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
      adj_q <= '0;
    end else begin
      line_start <= 1'b0;
      frame_start <= 1'b0;
      if (ce_pix) begin
        hcnt <= hcnt_n;
        vcnt <= vcnt_n;
        hb <= hb_n;
        vb <= vb_n;
        hs <= hs_n;
        vs <= vs_n;
        rgb_out <= (hb_n || vb_n) ? '0 : rgb_in;
        line_start <= hcnt_n == '0;
        frame_start <= hcnt_n == '0 && vcnt_n == '0;
        if (hcnt_n == '0 && vcnt_n == '0) adj_q <= h_adj;
      end
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench; a small-raster instance gets random stimulus and a
// default-parameter instance free-runs one full frame, both against a position-based model.
module tb_video_timing_gen;
  typedef struct packed {
    int ht; int ha; int hss; int hse; int hm; int vt; int va; int vss; int vse;
  } cfg_t;
  typedef struct packed {
    logic [31:0] h;
    logic [31:0] v;
    logic [23:0] rgb;
    logic hb; logic vb; logic hs; logic vs; logic ls; logic fs;
  } exp_t;
  localparam cfg_t SMALL = '{ht: 48, ha: 24, hss: 34, hse: 40, hm: 3, vt: 20, va: 15, vss: 16, vse: 18};
  localparam cfg_t DFLT = '{ht: 318, ha: 256, hss: 283, hse: 303, hm: 5, vt: 256, va: 240, vss: 251, vse: 254};
  localparam int NCYC = 83000;
  logic clk;
  logic rst_s, ce_s, mask_s, rst_d;
  logic [3:0] adj_s;
  logic [23:0] rgb_s, rgb_out_s, rgb_out_d;
  logic [5:0] hcnt_s;
  logic [4:0] vcnt_s;
  logic [8:0] hcnt_d;
  logic [7:0] vcnt_d;
  logic hb_s, vb_s, hs_s, vs_s, ls_s, fs_s;
  logic hb_d, vb_d, hs_d, vs_d, ls_d, fs_d;
  int tests = 0, fails = 0, hold = 0;
  int ts, as_, td, ad;
  exp_t es, ed, ms, md;
  exp_t qs[$], qd[$];
  video_timing_gen #(.H_TOTAL(48), .H_ACTIVE(24), .H_SYNC_START(34), .H_SYNC_END(40), .H_MASK(3),
    .V_TOTAL(20), .V_ACTIVE(15), .V_SYNC_START(16), .V_SYNC_END(18), .RGB_W(24)) dut_s (
    .clk_sys(clk), .reset(rst_s), .ce_pix(ce_s), .mask_en(mask_s), .h_adj(adj_s), .rgb_in(rgb_s),
    .rgb_out(rgb_out_s), .hcnt(hcnt_s), .vcnt(vcnt_s), .hb(hb_s), .vb(vb_s), .hs(hs_s), .vs(vs_s),
    .line_start(ls_s), .frame_start(fs_s));
  video_timing_gen dut_d (
    .clk_sys(clk), .reset(rst_d), .ce_pix(1'b1), .mask_en(1'b1), .h_adj(4'd7), .rgb_in(24'hA5C3F0),
    .rgb_out(rgb_out_d), .hcnt(hcnt_d), .vcnt(vcnt_d), .hb(hb_d), .vb(vb_d), .hs(hs_d), .vs(vs_d),
    .line_start(ls_d), .frame_start(fs_d));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  // Model tracks the raster position as a count of pixel enables since reset
  task automatic step(input cfg_t c, input logic rst, input logic ce, input logic mask,
                      input logic [3:0] ha, input logic [23:0] rgb,
                      inout int ticks, inout int adj, inout exp_t e);
    int h, v;
    if (rst) begin
      ticks = 0;
      adj = 0;
      e = '0;
      {e.hb, e.vb, e.hs, e.vs} = 4'b1111;
    end else if (!ce) begin
      e.ls = 0;
      e.fs = 0;
    end else begin
      ticks = (ticks + 1) % (c.ht * c.vt);
      h = ticks % c.ht;
      v = ticks / c.ht;
      e.h = 32'(h);
      e.v = 32'(v);
      e.hb = h >= c.ha || (mask && h < c.hm);
      e.vb = v >= c.va;
      e.hs = !(h >= c.hss + adj && h < c.hse + adj);
      e.vs = !(v >= c.vss && v < c.vse);
      e.rgb = (e.hb || e.vb) ? 24'h0 : rgb;
      e.ls = h == 0;
      e.fs = ticks == 0;
      if (ticks == 0) adj = int'($signed(ha));
    end
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (qs.size() > 0) begin
      ms = qs.pop_front();
      chk("s_hcnt", 32'(hcnt_s), ms.h);
      chk("s_vcnt", 32'(vcnt_s), ms.v);
      chk("s_hb", 32'(hb_s), 32'(ms.hb));
      chk("s_vb", 32'(vb_s), 32'(ms.vb));
      chk("s_hs", 32'(hs_s), 32'(ms.hs));
      chk("s_vs", 32'(vs_s), 32'(ms.vs));
      chk("s_rgb", 32'(rgb_out_s), 32'(ms.rgb));
      chk("s_line_start", 32'(ls_s), 32'(ms.ls));
      chk("s_frame_start", 32'(fs_s), 32'(ms.fs));
    end
    if (qd.size() > 0) begin
      md = qd.pop_front();
      chk("d_hcnt", 32'(hcnt_d), md.h);
      chk("d_vcnt", 32'(vcnt_d), md.v);
      chk("d_hb", 32'(hb_d), 32'(md.hb));
      chk("d_vb", 32'(vb_d), 32'(md.vb));
      chk("d_hs", 32'(hs_d), 32'(md.hs));
      chk("d_vs", 32'(vs_d), 32'(md.vs));
      chk("d_rgb", 32'(rgb_out_d), 32'(md.rgb));
      chk("d_line_start", 32'(ls_d), 32'(md.ls));
      chk("d_frame_start", 32'(fs_d), 32'(md.fs));
    end
  end
  initial begin
    rst_s = 1; rst_d = 1; ce_s = 0; mask_s = 0; adj_s = 0; rgb_s = 0;
    ts = 0; as_ = 0; td = 0; ad = 0; es = '0; ed = '0;
    for (int n = 0; n < NCYC; n++) begin
      @(negedge clk);
      rst_s = n < 3 || n == 40000 || $urandom_range(0, 9999) == 0;
      rst_d = n < 3;
      if (hold > 0) begin
        ce_s = 0;
        hold--;
      end else begin
        ce_s = $urandom_range(0, 4) != 0;
        if ($urandom_range(0, 1999) == 0) hold = 50;
      end
      if ($urandom_range(0, 499) == 0) mask_s = !mask_s;
      if ($urandom_range(0, 299) == 0) adj_s = 4'($urandom);
      rgb_s = 24'($urandom);
      step(SMALL, rst_s, ce_s, mask_s, adj_s, rgb_s, ts, as_, es);
      qs.push_back(es);
      step(DFLT, rst_d, 1'b1, 1'b1, 4'd7, 24'hA5C3F0, td, ad, ed);
      qd.push_back(ed);
    end
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
